executa_movimentos: RTL and testbench

Move-execution sequencer that sits directly downstream of the serial move receiver. After the receiver fills the move RAM, this block reads the stored 3-bit move codes one at a time from address 0. For each face move it enables that face's stepper driver and emits a fixed train of step pulses. It stops on the end-of-sequence code or at the last RAM address.

---
 rtl/rubik_pkg.sv | 45 ++++
 rtl/executa_movimentos_if.sv | 49 ++++
 rtl/gerador_passos.sv | 58 +++++
 rtl/executa_movimentos.sv | 136 +++++++++++++
 tb/tb_executa_movimentos.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rubik_pkg.sv
// Shared definitions for the move-execution path: move codes, the
// sequencer state encoding and the move-code to driver-enable mapping.
package rubik_pkg;

  localparam int MOV_W = 3;

  // Face move codes, clockwise 90 degrees
  localparam logic [MOV_W-1:0] FACE_U  = 3'd0;
  localparam logic [MOV_W-1:0] FACE_D  = 3'd1;
  localparam logic [MOV_W-1:0] FACE_F  = 3'd2;
  localparam logic [MOV_W-1:0] FACE_B  = 3'd3;
  localparam logic [MOV_W-1:0] FACE_L  = 3'd4;
  localparam logic [MOV_W-1:0] FACE_R  = 3'd5;
  localparam logic [MOV_W-1:0] MOV_NOP = 3'd6;
  localparam logic [MOV_W-1:0] MOV_FIM = 3'd7;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    ZERA       = 4'd1,
    LE         = 4'd2,
    ESPERA_MEM = 4'd3,
    DECODIFICA = 4'd4,
    GIRA       = 4'd5,
    PAUSA      = 4'd6,
    INCREMENTA = 4'd7,
    FIM        = 4'd8
  } estado_t;

  // One-hot driver enable for a face code; NOP and FIM_SEQ enable nothing
  function automatic logic [5:0] habilita_face(input logic [MOV_W-1:0] mov);
    logic [5:0] h;
    h = '0;
    case (mov)
      FACE_U:  h = 6'b000001;
      FACE_D:  h = 6'b000010;
      FACE_F:  h = 6'b000100;
      FACE_B:  h = 6'b001000;
      FACE_L:  h = 6'b010000;
      FACE_R:  h = 6'b100000;
      default: h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/executa_movimentos_if.sv
// Signal bundle between the move sequencer, the move RAM and the stepper
// drivers. Debug signals exist only when EXEC_DEBUG_EN is defined.
//
// Handshake: iniciar is a level request, looked at only while the
// sequencer is idle (INICIAL) or finished (FIM); it must drop after pronto
// before a new run can begin. dado_mem is the synchronous RAM read data,
// valid one cycle after endereco changes. pronto is a one-cycle pulse;
// ocupado is a level that is high for the whole run.
interface executa_movimentos_if #(
  parameter int ADDR_W = 6
);
  import rubik_pkg::*;

  logic              iniciar;
  logic [MOV_W-1:0]  dado_mem;
  logic [ADDR_W-1:0] endereco;
  logic              passo;
  logic [5:0]        habilita_motor;
  logic              ocupado;
  logic              pronto;

`ifdef EXEC_DEBUG_EN
  logic [3:0]        db_estado;
  logic [7:0]        db_movimentos;

  modport master (
    input  iniciar, dado_mem,
    output endereco, passo, habilita_motor, ocupado, pronto,
           db_estado, db_movimentos
  );

  modport slave (
    output iniciar, dado_mem,
    input  endereco, passo, habilita_motor, ocupado, pronto,
           db_estado, db_movimentos
  );
`else
  modport master (
    input  iniciar, dado_mem,
    output endereco, passo, habilita_motor, ocupado, pronto
  );

  modport slave (
    output iniciar, dado_mem,
    input  endereco, passo, habilita_motor, ocupado, pronto
  );
`endif

endinterface

// File: rtl/gerador_passos.sv
// Step-pulse generator: on inicia emits PASSOS pulses, each MEIO_PERIODO
// cycles high then MEIO_PERIODO cycles low, starting high on the next cycle.
// fim is high during the final cycle of the last low half-period so the
// caller can leave its turning state exactly when the train ends.
module gerador_passos #(
  parameter int PASSOS       = 50,
  parameter int MEIO_PERIODO = 25000
) (
  input  logic clock,
  input  logic reset,
  input  logic inicia,
  output logic passo,
  output logic fim
);

  localparam int TW = (MEIO_PERIODO > 1) ? $clog2(MEIO_PERIODO) : 1;
  localparam int CW = (PASSOS > 1) ? $clog2(PASSOS) : 1;

  logic          ativo;
  logic [TW-1:0] tempo;
  logic [CW-1:0] conta;
  logic          fim_meio;
  logic          ultimo_passo;

  assign fim_meio     = (tempo == TW'(MEIO_PERIODO - 1));
  assign ultimo_passo = (conta == CW'(PASSOS - 1));
  assign fim          = ativo && !passo && fim_meio && ultimo_passo;

  // Half-period timer, pulse counter and the registered step output
  always_ff @(posedge clock) begin
    if (!reset) begin
      ativo <= 1'b0;
      passo <= 1'b0;
      tempo <= '0;
      conta <= '0;
    end else if (inicia) begin
      ativo <= 1'b1;
      passo <= 1'b1;
      tempo <= '0;
      conta <= '0;
    end else if (ativo) begin
      if (fim_meio) begin
        tempo <= '0;
        if (passo) begin
          passo <= 1'b0;
        end else if (ultimo_passo) begin
          ativo <= 1'b0;
        end else begin
          passo <= 1'b1;
          conta <= conta + 1'b1;
        end
      end else begin
        tempo <= tempo + 1'b1;
      end
    end
  end

endmodule

// File: rtl/executa_movimentos.sv
// Move-execution sequencer: walks the move RAM from address 0, turns one
// face per stored code, pauses after each turn, and stops on FIM_SEQ or at
// the last RAM address. Optional debug outputs under EXEC_DEBUG_EN.
module executa_movimentos
  import rubik_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int PASSOS       = 50,
  parameter int MEIO_PERIODO = 25000,
  parameter int PAUSA_CICLOS = 2500000
) (
  input  logic                 clock,
  input  logic                 reset,
  executa_movimentos_if.master bus
);

  localparam int PW = (PAUSA_CICLOS > 1) ? $clog2(PAUSA_CICLOS) : 1;
  localparam logic [ADDR_W-1:0] END_MAX = '1;

  estado_t           estado;
  estado_t           proximo;
  logic              inicia_gira;
  logic              fim_gira;
  logic              pausa_fim;
  logic [ADDR_W-1:0] endereco;
  logic [MOV_W-1:0]  movimento;
  logic [PW-1:0]     pausa_cnt;
  logic [5:0]        habilita;
  logic              ocupado;
  logic              pronto;
  logic              passo;

  assign pausa_fim = (pausa_cnt == PW'(PAUSA_CICLOS - 1));

  gerador_passos #(
    .PASSOS      (PASSOS),
    .MEIO_PERIODO(MEIO_PERIODO)
  ) u_gerador (
    .clock (clock),
    .reset (reset),
    .inicia(inicia_gira),
    .passo (passo),
    .fim   (fim_gira)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Next-state decode; the step generator is started on the GIRA entry edge
  always_comb begin
    proximo     = estado;
    inicia_gira = 1'b0;
    case (estado)
      INICIAL:    if (bus.iniciar) proximo = ZERA;
      ZERA:       proximo = LE;
      LE:         proximo = ESPERA_MEM;
      ESPERA_MEM: proximo = DECODIFICA;
      DECODIFICA: begin
        if (movimento == MOV_FIM) begin
          proximo = FIM;
        end else if (movimento == MOV_NOP) begin
          proximo = INCREMENTA;
        end else begin
          proximo     = GIRA;
          inicia_gira = 1'b1;
        end
      end
      GIRA:       if (fim_gira) proximo = PAUSA;
      PAUSA:      if (pausa_fim) proximo = INCREMENTA;
      INCREMENTA: proximo = (endereco == END_MAX) ? FIM : LE;
      FIM:        if (!bus.iniciar) proximo = INICIAL;
      default:    proximo = INICIAL;
    endcase
  end

  // Read address: cleared in ZERA, advanced in INCREMENTA, never wraps
  always_ff @(posedge clock) begin
    if (!reset) begin
      endereco <= '0;
    end else if (estado == ZERA) begin
      endereco <= '0;
    end else if (estado == INCREMENTA && endereco != END_MAX) begin
      endereco <= endereco + 1'b1;
    end
  end

  // Move register captures RAM data once it has settled
  always_ff @(posedge clock) begin
    if (!reset)                     movimento <= '0;
    else if (estado == ESPERA_MEM)  movimento <= bus.dado_mem;
  end

  // Settle timer, running only while in PAUSA
  always_ff @(posedge clock) begin
    if (!reset)               pausa_cnt <= '0;
    else if (estado == PAUSA) pausa_cnt <= pausa_cnt + 1'b1;
    else                      pausa_cnt <= '0;
  end

  // Registered outputs computed from the state being entered
  always_ff @(posedge clock) begin
    if (!reset) begin
      habilita <= '0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      habilita <= (proximo == GIRA) ? habilita_face(movimento) : '0;
      ocupado  <= (proximo != INICIAL) && (proximo != FIM);
      pronto   <= (proximo == FIM) && (estado != FIM);
    end
  end

  assign bus.endereco       = endereco;
  assign bus.passo          = passo;
  assign bus.habilita_motor = habilita;
  assign bus.ocupado        = ocupado;
  assign bus.pronto         = pronto;

`ifdef EXEC_DEBUG_EN
  logic [7:0] db_mov;

  // Face moves started in this run, saturating at 255
  always_ff @(posedge clock) begin
    if (!reset)                           db_mov <= '0;
    else if (estado == ZERA)              db_mov <= '0;
    else if (inicia_gira && db_mov != '1) db_mov <= db_mov + 1'b1;
  end

  assign bus.db_estado     = estado;
  assign bus.db_movimentos = db_mov;
`endif

endmodule

// File: tb/tb_executa_movimentos.sv
// Directed bench for executa_movimentos with a small synchronous RAM model.
// Reduced parameters: PASSOS=3, MEIO_PERIODO=2, PAUSA_CICLOS=4, ADDR_W=3.
// Debug checks are compiled in when EXEC_DEBUG_EN is defined.
module tb_executa_movimentos;
  import rubik_pkg::*;

  localparam int ADDR_W = 3;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  executa_movimentos_if #(.ADDR_W(ADDR_W)) bus ();

  executa_movimentos #(
    .ADDR_W      (ADDR_W),
    .PASSOS      (3),
    .MEIO_PERIODO(2),
    .PAUSA_CICLOS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous-read move RAM
  logic [2:0] ram [8];
  always @(posedge clock) bus.dado_mem <= ram[bus.endereco];

  // per-run observation state
  int         cyc, rises, high_cyc, hab_cyc, pronto_cnt, hab_bad, first_rise_end;
  logic       prev_passo;
  logic [5:0] hab_or;
  logic [2:0] prev_end;
  bit         seen_zero, wrapped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_ram(input logic [2:0] v);
    for (int i = 0; i < 8; i++) ram[i] = v;
  endtask

  task automatic clear_stats();
    cyc = 0; rises = 0; high_cyc = 0; hab_cyc = 0; pronto_cnt = 0; hab_bad = 0;
    first_rise_end = -1; prev_passo = 1'b0; hab_or = '0; prev_end = '0;
    seen_zero = 0; wrapped = 0;
  endtask

  // called once per cycle at the falling edge
  task automatic sample();
    if (bus.passo && !prev_passo) begin
      if (rises == 0) first_rise_end = int'(bus.endereco);
      rises++;
    end
    prev_passo = bus.passo;
    if (bus.passo) high_cyc++;
    if (bus.habilita_motor != 6'b0) begin
      hab_cyc++;
      hab_or = hab_or | bus.habilita_motor;
    end
    if (bus.passo && bus.habilita_motor == 6'b0) hab_bad++;
    if ((bus.habilita_motor & (bus.habilita_motor - 6'd1)) != 6'b0) hab_bad++;
    if (bus.pronto) pronto_cnt++;
    if (seen_zero && bus.endereco < prev_end) wrapped = 1;
    if (cyc >= 2 && bus.endereco == '0) seen_zero = 1;
    prev_end = bus.endereco;
  endtask

  // start a run and observe it through FIM and back to idle
  task automatic run_seq(input string name, input int exp_cyc, input int exp_rises,
                         input logic [5:0] exp_hab, input logic [5:0] exp_hab_first,
                         input int exp_first_rise_end, input bit first_face,
                         input int exp_last_end, input bit hold);
    bit done;
    done = 0;
    clear_stats();
    @(negedge clock);
    bus.iniciar = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      sample();
      if (cyc == 1) check({name, " ocupado_zera"}, 32'(bus.ocupado), 32'd1);
      if (cyc == 2) check({name, " endereco_le"}, 32'(bus.endereco), 32'd0);
      if (cyc == 5) begin
        check({name, " passo_k5"}, 32'(bus.passo), 32'(first_face));
        check({name, " habilita_k5"}, 32'(bus.habilita_motor), 32'(exp_hab_first));
      end
`ifdef EXEC_DEBUG_EN
      if (cyc == 1) check({name, " db_estado_zera"}, 32'(bus.db_estado), 32'(ZERA));
      if (cyc == 2) check({name, " db_estado_le"}, 32'(bus.db_estado), 32'(LE));
      if (cyc == 3) check({name, " db_estado_espera"}, 32'(bus.db_estado), 32'(ESPERA_MEM));
      if (cyc == 5) check({name, " db_estado_k5"}, 32'(bus.db_estado),
                          first_face ? 32'(GIRA) : 32'(INCREMENTA));
`endif
      if (bus.pronto) begin
        done = 1;
`ifdef EXEC_DEBUG_EN
        check({name, " db_estado_fim"}, 32'(bus.db_estado), 32'(FIM));
        check({name, " db_movimentos"}, 32'(bus.db_movimentos), 32'(exp_rises / 3));
`endif
      end
    end
    check({name, " cycles_to_pronto"}, 32'(cyc), 32'(exp_cyc));
    if (hold) begin
      repeat (40) begin
        @(negedge clock);
        cyc++;
        sample();
      end
    end
    bus.iniciar = 1'b0;
    repeat (3) begin
      @(negedge clock);
      cyc++;
      sample();
    end
    check({name, " rises"}, 32'(rises), 32'(exp_rises));
    check({name, " high_cycles"}, 32'(high_cyc), 32'(exp_rises * 2));
    check({name, " enable_cycles"}, 32'(hab_cyc), 32'(exp_rises * 4));
    check({name, " enable_faces"}, 32'(hab_or), 32'(exp_hab));
    check({name, " enable_bad"}, 32'(hab_bad), 32'd0);
    check({name, " first_rise_addr"}, 32'(first_rise_end), 32'(exp_first_rise_end));
    check({name, " pronto_count"}, 32'(pronto_cnt), 32'd1);
    check({name, " last_addr"}, 32'(bus.endereco), 32'(exp_last_end));
    check({name, " no_wrap"}, 32'(wrapped), 32'd0);
    check({name, " ocupado_after"}, 32'(bus.ocupado), 32'd0);
  endtask

  // reset asserted on the second step pulse of a turn at address 1
  task automatic reset_mid_turn();
    fill_ram(MOV_FIM);
    ram[0] = MOV_NOP;
    ram[1] = FACE_F;
    clear_stats();
    @(negedge clock);
    bus.iniciar = 1'b1;
    while (rises < 2 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      sample();
    end
    check("rst reached_pulse2", 32'(rises), 32'd2);
    check("rst addr_before", 32'(bus.endereco), 32'd1);
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    @(negedge clock);
    check("rst passo", 32'(bus.passo), 32'd0);
    check("rst habilita", 32'(bus.habilita_motor), 32'd0);
    check("rst endereco", 32'(bus.endereco), 32'd0);
    check("rst ocupado", 32'(bus.ocupado), 32'd0);
    check("rst pronto", 32'(bus.pronto), 32'd0);
`ifdef EXEC_DEBUG_EN
    check("rst db_estado", 32'(bus.db_estado), 32'(INICIAL));
`endif
    reset = 1'b1;
    pronto_cnt = 0;
    rises = 0;
    repeat (30) begin
      @(negedge clock);
      sample();
    end
    check("rst no_pronto", 32'(pronto_cnt), 32'd0);
    check("rst no_pulses_after", 32'(rises), 32'd0);
    check("rst idle_ocupado", 32'(bus.ocupado), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    fill_ram(MOV_FIM);
    repeat (3) @(negedge clock);
    check("reset endereco", 32'(bus.endereco), 32'd0);
    check("reset passo", 32'(bus.passo), 32'd0);
    check("reset habilita", 32'(bus.habilita_motor), 32'd0);
    check("reset ocupado", 32'(bus.ocupado), 32'd0);
    check("reset pronto", 32'(bus.pronto), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // {F, FIM}: ZERA + 3 + 12 GIRA + 4 PAUSA + 1 INCR + 3 -> FIM at cycle 25
    fill_ram(MOV_FIM);
    ram[0] = FACE_F;
    run_seq("seq27", 25, 3, 6'b000100, 6'b000100, 0, 1, 1, 0);

    // {NOP, NOP, U, FIM}: 1 + 4 + 4 + 20 + 3 -> FIM at cycle 33
    fill_ram(MOV_FIM);
    ram[0] = MOV_NOP;
    ram[1] = MOV_NOP;
    ram[2] = FACE_U;
    run_seq("nop", 33, 3, 6'b000001, 6'b000000, 2, 0, 3, 0);

    // all R, no FIM_SEQ: 1 + 8*20 -> FIM at cycle 162, stops at address 7
    fill_ram(FACE_R);
    run_seq("all5", 162, 24, 6'b100000, 6'b100000, 0, 1, 7, 0);

    reset_mid_turn();

    // iniciar held through FIM, then dropped and raised again
    fill_ram(MOV_FIM);
    ram[0] = FACE_F;
    run_seq("hold", 25, 3, 6'b000100, 6'b000100, 0, 1, 1, 1);
    run_seq("restart", 25, 3, 6'b000100, 6'b000100, 0, 1, 1, 0);

    // {U, NOP, D, FIM}: 1 + 20 + 4 + 20 + 3 -> FIM at cycle 49, two face moves
    fill_ram(MOV_FIM);
    ram[0] = FACE_U;
    ram[1] = MOV_NOP;
    ram[2] = FACE_D;
    run_seq("dbg0617", 49, 6, 6'b000011, 6'b000001, 0, 1, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
